rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. It tracks a 3-bit grant index, expands it to a one-hot grant vector with the same mapping as a 3-to-8 decoder, and bounds each tenure with a programmable hold limit. It sits between the requester bank and the shared datapath, and is the sequencer for the decoder-selected resource.

---
 rtl/rr_arbiter8.sv | 144 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a programmable hold limit.
// A 3-bit grant index is decoded to a one-hot grant vector. Every tenure ends
// when the grantee releases its request or reaches HOLD_MAX cycles.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_vld,
  output logic       timeout
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Round-robin search result.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             grant_vld_q, grant_vld_d;
  logic             timeout_q, timeout_d;
  logic             tenure_timeout_c;
  pick_t            pick_c;

  // Search base+1 .. base+8 (mod 8); the first set request wins, so base itself
  // is considered last.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] r,
                                    input logic [IDX_W-1:0] base);
    pick_t            p;
    logic [IDX_W-1:0] cand;
    p.found = 1'b0;
    p.idx   = base;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = base + IDX_W'(k);
      if (!p.found && r[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  // 3-to-8 decode of the grant index.
  function automatic logic [N_REQ-1:0] dec3to8(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // State register and all datapath flops; reset is asynchronous.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      timeout_q   <= timeout_d;
    end
  end

  // Search base: the stored pointer when idle, the current grantee when busy.
  always_comb begin
    pick_c = rr_pick(req, (state_q == ST_BUSY) ? grant_idx_q : last_q);
  end

  // Next-state, grant index, hold counter and round-robin pointer.
  always_comb begin
    state_d          = state_q;
    grant_idx_d      = grant_idx_q;
    hold_cnt_d       = hold_cnt_q;
    last_d           = last_q;
    tenure_timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_c.found) begin
          state_d     = ST_BUSY;
          grant_idx_d = pick_c.idx;
          hold_cnt_d  = '0;
        end
      end
      ST_BUSY: begin
        if (!req[grant_idx_q]) begin
          // Release: the grantee cannot win again since its request is low.
          last_d     = grant_idx_q;
          hold_cnt_d = '0;
          if (pick_c.found) begin
            grant_idx_d = pick_c.idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Hold limit: a sole requester wins its own re-arbitration.
          last_d           = grant_idx_q;
          tenure_timeout_c = 1'b1;
          grant_idx_d      = pick_c.idx;
          hold_cnt_d       = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the next state, so grant and index move together.
  always_comb begin
    grant_vld_d = (state_d == ST_BUSY);
    grant_d     = grant_vld_d ? dec3to8(grant_idx_d) : '0;
    timeout_d   = tenure_timeout_c;
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign grant_vld = grant_vld_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with HOLD_MAX=4.
module tb_rr_arbiter8;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vq[$];

  rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                         input logic ev, input logic et);
    chk({tag, " grant"}, grant, eg);
    chk({tag, " idx"}, 8'(grant_idx), 8'(ei));
    chk({tag, " vld"}, 8'(grant_vld), 8'(ev));
    chk({tag, " timeout"}, 8'(timeout), 8'(et));
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] eg, input logic [2:0] ei,
                      input logic ev, input logic et, input string tag);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
    chk_all(tag, eg, ei, ev, et);
  endtask

  task automatic do_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req   = r;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] i,
                     input logic v, input logic t);
    vec_t v_rec;
    v_rec.req = r; v_rec.grant = g; v_rec.idx = i; v_rec.vld = v; v_rec.to = t;
    vq.push_back(v_rec);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;

    // Sequence after reset (last=7), one entry per clock edge.
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h03, 8'h02, 3'd1, 1'b1, 1'b1);
    add(8'h03, 8'h02, 3'd1, 1'b1, 1'b0);
    add(8'h03, 8'h02, 3'd1, 1'b1, 1'b0);
    add(8'h03, 8'h02, 3'd1, 1'b1, 1'b0);
    add(8'h03, 8'h01, 3'd0, 1'b1, 1'b1);
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h84, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h84, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    add(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      add(8'h10, 8'h10, 3'd4, 1'b1, (n == 1) ? 1'b1 : 1'b0);
      add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
      add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
      add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    end
    add(8'h10, 8'h10, 3'd4, 1'b1, 1'b1);
    add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
    add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h40, 8'h40, 3'd6, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd6, 1'b0, 1'b0);

    rst_n = 1'b1;
    req   = 8'h00;
    #2;

    // Reset with all requests pending, then first grant goes to requester 0.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'hFF;
    #1;
    chk_all("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_first", 8'h01, 3'd0, 1'b1, 1'b0);

    // Rotation: each grantee holds 3 cycles then drops for one edge.
    for (int k = 0; k < 8; k++) begin
      cur = 8'h01 << k;
      nxt = 8'h01 << ((k + 1) % 8);
      step(8'hFF, cur, 3'(k), 1'b1, 1'b0, $sformatf("rot%0d_c2", k));
      step(8'hFF, cur, 3'(k), 1'b1, 1'b0, $sformatf("rot%0d_c3", k));
      step(8'hFF & ~cur, nxt, 3'((k + 1) % 8), 1'b1, 1'b0, $sformatf("rot%0d_hand", k));
    end

    // Asynchronous reset mid-tenure.
    do_reset(8'h00);
    step(8'h08, 8'h08, 3'd3, 1'b1, 1'b0, "mid_grant");
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h08;
    #1;
    chk_all("mid_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("mid_regrant", 8'h08, 3'd3, 1'b1, 1'b0);

    // Table-driven sequence from a fresh reset.
    do_reset(8'h00);
    foreach (vq[n]) begin
      step(vq[n].req, vq[n].grant, vq[n].idx, vq[n].vld, vq[n].to, $sformatf("vec%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
